// File: rtl/mem_responder_pkg.sv
// Shared widths and defaults for the cache-side memory responder.
// The latency default tracks the icache MEMORY_READ_DELAY tuning.
package mem_responder_pkg;

  localparam int ADDR_W           = 16;
  localparam int DATA_W           = 32;
  localparam int MEM_WORDS_DEF    = 1024;
  localparam int WBUF_DEPTH_DEF   = 4;
  localparam int READ_LATENCY_DEF = 1;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] word_t;

endpackage

// File: rtl/mem_wbuf.sv
// Posted-write FIFO with a parallel index compare.
// The lookup returns the newest matching entry for forwarding.
module mem_wbuf
  import mem_responder_pkg::*;
#(
  parameter int DEPTH = WBUF_DEPTH_DEF,
  parameter int IDX_W = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [IDX_W-1:0] push_idx,
  input  word_t            push_data,
  input  logic             pop,
  output logic [IDX_W-1:0] head_idx,
  output word_t            head_data,
  output logic             empty,
  output logic             full,
  input  logic [IDX_W-1:0] look_idx,
  output logic             hit,
  output word_t            hit_data
);

  localparam int PW = $clog2(DEPTH);

  logic [IDX_W-1:0] idx_q [DEPTH];
  word_t            data_q [DEPTH];

  logic [PW-1:0] wp_q, wp_d;
  logic [PW-1:0] rp_q, rp_d;
  logic [PW:0]   cnt_q, cnt_d;

  assign empty     = (cnt_q == '0);
  assign full      = (cnt_q == (PW+1)'(DEPTH));
  assign head_idx  = idx_q[rp_q];
  assign head_data = data_q[rp_q];

  // Pointer and occupancy update for push/pop.
  always_comb begin
    wp_d  = wp_q + PW'(push);
    rp_d  = rp_q + PW'(pop);
    cnt_d = cnt_q + (PW+1)'(push) - (PW+1)'(pop);
  end

  // Pointer state; cleared on reset, dropping buffered writes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
    end
  end

  // Entry storage; validity is owned by the pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      idx_q[wp_q]  <= push_idx;
      data_q[wp_q] <= push_data;
    end
  end

  // Scan oldest to newest so the newest match wins.
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (((PW+1)'(k) < cnt_q) &&
          (idx_q[rp_q + PW'(k)] == look_idx)) begin
        hit      = 1'b1;
        hit_data = data_q[rp_q + PW'(k)];
      end
    end
  end

endmodule

// File: rtl/mem_responder.sv
// Word-addressed backing memory for the cache: posted writes,
// read priority over drain, forwarding and a pipelined read path.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int READ_LATENCY = READ_LATENCY_DEF,
  parameter int WBUF_DEPTH   = WBUF_DEPTH_DEF,
  parameter int MEM_WORDS    = MEM_WORDS_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              busy,
  output logic              wr_overflow
);

  localparam int IDX_W = $clog2(MEM_WORDS);
  localparam int RL    = READ_LATENCY;

  logic [IDX_W-1:0] rd_idx, wr_idx, head_idx;
  word_t            head_data, hit_data, rd_word;
  logic             empty, full, hit;
  logic             push, pop;
  logic             unused_addr;

  word_t mem_q [MEM_WORDS];

  logic [RL-1:0] vld_q, vld_d;
  word_t         dat_q [RL];
  word_t         dat_d [RL];
  logic          ovf_q, ovf_d;

  assign rd_idx      = rd_addr[IDX_W+1:2];
  assign wr_idx      = wr_addr[IDX_W+1:2];
  assign unused_addr = ^{rd_addr, wr_addr};

  // Reads own the array port; a full buffer still takes a write
  // when its head drains in the same cycle.
  assign pop  = ~empty & ~rd_en;
  assign push = wr_en & (~full | pop);

  mem_wbuf #(
    .DEPTH (WBUF_DEPTH),
    .IDX_W (IDX_W)
  ) u_wbuf (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_idx  (wr_idx),
    .push_data (wr_data),
    .pop       (pop),
    .head_idx  (head_idx),
    .head_data (head_data),
    .empty     (empty),
    .full      (full),
    .look_idx  (rd_idx),
    .hit       (hit),
    .hit_data  (hit_data)
  );

  assign rd_word = hit ? hit_data : mem_q[rd_idx];

  // Drain the buffer head into the array; contents survive reset.
  always_ff @(posedge clk) begin
    if (pop) begin
      mem_q[head_idx] <= head_data;
    end
  end

  // Shift the read pipeline; data stages hold until a new response.
  always_comb begin
    vld_d[0] = rd_en;
    dat_d[0] = rd_en ? rd_word : dat_q[0];
    for (int i = 1; i < RL; i++) begin
      vld_d[i] = vld_q[i-1];
      dat_d[i] = vld_q[i-1] ? dat_q[i-1] : dat_q[i];
    end
    ovf_d = ovf_q | (wr_en & ~push);
  end

  // Read pipeline and sticky overflow state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      ovf_q <= 1'b0;
      for (int i = 0; i < RL; i++) begin
        dat_q[i] <= '0;
      end
    end else begin
      vld_q <= vld_d;
      ovf_q <= ovf_d;
      for (int i = 0; i < RL; i++) begin
        dat_q[i] <= dat_d[i];
      end
    end
  end

  assign rd_valid    = vld_q[RL-1];
  assign rd_data     = dat_q[RL-1];
  assign busy        = ~empty;
  assign wr_overflow = ovf_q;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder at read latencies 1 and 3, driven
// in lockstep against a transaction-level memory model.
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd_en, wr_en;
  logic [15:0] rd_addr, wr_addr;
  logic [31:0] wr_data;

  logic [31:0] rd_data1, rd_data3;
  logic        rd_valid1, rd_valid3;
  logic        busy1, busy3, ovf1, ovf3;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_responder #(
    .READ_LATENCY (1),
    .WBUF_DEPTH   (4),
    .MEM_WORDS    (1024)
  ) dut1 (
    .clk         (clk),
    .rst         (rst),
    .rd_en       (rd_en),
    .rd_addr     (rd_addr),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .rd_data     (rd_data1),
    .rd_valid    (rd_valid1),
    .busy        (busy1),
    .wr_overflow (ovf1)
  );

  mem_responder #(
    .READ_LATENCY (3),
    .WBUF_DEPTH   (4),
    .MEM_WORDS    (1024)
  ) dut3 (
    .clk         (clk),
    .rst         (rst),
    .rd_en       (rd_en),
    .rd_addr     (rd_addr),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .rd_data     (rd_data3),
    .rd_valid    (rd_valid3),
    .busy        (busy3),
    .wr_overflow (ovf3)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct { int idx; logic [31:0] d; } wr_t;
  typedef struct { int due; logic [31:0] d; } rsp_t;

  logic [31:0] mem_m [int];
  wr_t         wq [$];
  rsp_t        rq1 [$];
  rsp_t        rq3 [$];
  int          cyc_n = 0;
  logic        ovf_m = 1'b0;
  logic [31:0] last1 = '0;
  logic [31:0] last3 = '0;

  function automatic int widx(input logic [15:0] a);
    return int'(a[11:2]);
  endfunction

  function automatic logic [31:0] lookup(input int i);
    logic [31:0] v;
    v = mem_m.exists(i) ? mem_m[i] : 32'h0;
    foreach (wq[j]) if (wq[j].idx == i) v = wq[j].d;
    return v;
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        wq.delete();
        rq1.delete();
        rq3.delete();
        ovf_m = 1'b0;
        last1 = '0;
        last3 = '0;
      end else begin
        logic [31:0] v;
        if (rd_en) begin
          v = lookup(widx(rd_addr));
          rq1.push_back('{cyc_n + 1, v});
          rq3.push_back('{cyc_n + 3, v});
        end else if (wq.size() > 0) begin
          mem_m[wq[0].idx] = wq[0].d;
          void'(wq.pop_front());
        end
        if (wr_en) begin
          if (wq.size() >= 4) ovf_m = 1'b1;
          else wq.push_back('{widx(wr_addr), wr_data});
        end
      end
      cyc_n++;
    end
  end

  // Compare both instances against the model every cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (rq1.size() > 0 && rq1[0].due == cyc_n) begin
          last1 = rq1[0].d;
          void'(rq1.pop_front());
          chk("m1_valid", 32'(rd_valid1), 32'd1);
        end else begin
          chk("m1_valid", 32'(rd_valid1), 32'd0);
        end
        chk("m1_data", rd_data1, last1);
        if (rq3.size() > 0 && rq3[0].due == cyc_n) begin
          last3 = rq3[0].d;
          void'(rq3.pop_front());
          chk("m3_valid", 32'(rd_valid3), 32'd1);
        end else begin
          chk("m3_valid", 32'(rd_valid3), 32'd0);
        end
        chk("m3_data", rd_data3, last3);
        chk("m1_busy", 32'(busy1), 32'(wq.size() != 0));
        chk("m3_busy", 32'(busy3), 32'(wq.size() != 0));
        chk("m1_ovf", 32'(ovf1), 32'(ovf_m));
        chk("m3_ovf", 32'(ovf3), 32'(ovf_m));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input logic r, input logic [15:0] ra,
                      input logic w, input logic [15:0] wa,
                      input logic [31:0] wd);
    rd_en   = r;
    rd_addr = ra;
    wr_en   = w;
    wr_addr = wa;
    wr_data = wd;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 16'h0, 1'b0, 16'h0, 32'h0);
  endtask

  task automatic wr(input logic [15:0] a, input logic [31:0] d);
    step(1'b0, 16'h0, 1'b1, a, d);
  endtask

  task automatic rd(input logic [15:0] a);
    step(1'b1, a, 1'b0, 16'h0, 32'h0);
  endtask

  initial begin
    rst = 1'b1;
    rd_en = 1'b0; rd_addr = '0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_valid1", 32'(rd_valid1), 32'd0);
    chk("rst_data1", rd_data1, 32'h0);
    chk("rst_busy1", 32'(busy1), 32'd0);
    chk("rst_ovf1", 32'(ovf1), 32'd0);
    chk("rst_valid3", 32'(rd_valid3), 32'd0);
    chk("rst_data3", rd_data3, 32'h0);

    // Known array contents for later reads.
    wr(16'h0100, 32'h0BAD0100);
    wr(16'h0030, 32'h00000000);
    wr(16'h0060, 32'h60000001);
    wr(16'h0064, 32'h60000002);
    wr(16'h0068, 32'h60000003);
    wr(16'h0200, 32'hA0A0A0A0);
    wr(16'h0204, 32'hA1A1A1A1);
    wr(16'h0208, 32'hA2A2A2A2);
    idle(6);
    chk("preload_busy", 32'(busy1), 32'd0);

    // Posted write, drained, then read back; byte offset aliases.
    wr(16'h0010, 32'hDEADBEEF);
    idle(5);
    chk("wr_idle_busy", 32'(busy1), 32'd0);
    rd(16'h0012);
    chk("wr_rd_valid", 32'(rd_valid1), 32'd1);
    chk("wr_rd_data", rd_data1, 32'hDEADBEEF);
    idle(3);

    // Newest buffered write forwarded while reads block draining.
    step(1'b1, 16'h0100, 1'b1, 16'h0020, 32'h11111111);
    step(1'b1, 16'h0100, 1'b1, 16'h0020, 32'h22222222);
    rd(16'h0020);
    chk("fwd_data", rd_data1, 32'h22222222);
    chk("fwd_busy", 32'(busy1), 32'd1);
    idle(4);

    // Same-cycle write is invisible to the read beside it.
    step(1'b1, 16'h0030, 1'b1, 16'h0030, 32'hAAAA5555);
    chk("same_cyc_data", rd_data1, 32'h0);
    rd(16'h0030);
    chk("next_rd_data", rd_data1, 32'hAAAA5555);
    idle(4);

    // Fill under continuous reads; fifth write is dropped.
    for (int k = 0; k < 5; k++)
      step(1'b1, 16'h0100, 1'b1, 16'(16'h0040 + 4 * k),
           32'h35350000 + 32'(k));
    chk("ovf_set", 32'(ovf1), 32'd1);
    idle(6);
    chk("ovf_sticky", 32'(ovf1), 32'd1);
    for (int k = 0; k < 4; k++) begin
      rd(16'(16'h0040 + 4 * k));
      chk("fill_rd", rd_data1, 32'h35350000 + 32'(k));
    end
    idle(3);

    // Back-to-back reads at latency 3.
    rd(16'h0200);
    rd(16'h0204);
    rd(16'h0208);
    chk("l3_c3_valid", 32'(rd_valid3), 32'd1);
    chk("l3_c3_data", rd_data3, 32'hA0A0A0A0);
    idle(1);
    chk("l3_c4_data", rd_data3, 32'hA1A1A1A1);
    idle(1);
    chk("l3_c5_data", rd_data3, 32'hA2A2A2A2);
    idle(1);
    chk("l3_c6_valid", 32'(rd_valid3), 32'd0);
    chk("l3_hold", rd_data3, 32'hA2A2A2A2);
    idle(2);

    // Reset with buffered writes and a read in flight.
    step(1'b1, 16'h0100, 1'b1, 16'h0060, 32'hBBBB0001);
    step(1'b1, 16'h0100, 1'b1, 16'h0064, 32'hBBBB0002);
    step(1'b1, 16'h0100, 1'b1, 16'h0068, 32'hBBBB0003);
    chk("pre_rst_busy", 32'(busy1), 32'd1);
    rd_en = 1'b0;
    wr_en = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst_busy", 32'(busy3), 32'd0);
    chk("rst_ovf", 32'(ovf3), 32'd0);
    chk("rst_no_valid", 32'(rd_valid3), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("post_rst_valid3", 32'(rd_valid3), 32'd0);
      idle(1);
    end
    rd(16'h0060);
    chk("rst_arr0", rd_data1, 32'h60000001);
    rd(16'h0064);
    chk("rst_arr1", rd_data1, 32'h60000002);
    rd(16'h0068);
    chk("rst_arr2", rd_data1, 32'h60000003);
    chk("rst_arr_l3", rd_data3, 32'h60000001);
    idle(4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
